// File: rtl/axis_packetizer_pkg.sv
// -----------------------------------------------------------------------------
// axis_packetizer_pkg
// Shared definitions for the AXI-Stream packetizer:
//   - FSM state encoding (legacy localparam constants plus an enum view)
//   - lane-index constants for the output packet word
//   - default header value placed in lane 0
//   - helper mapping an input channel to its output lane
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package axis_packetizer_pkg;

    localparam logic [0:0] ST_ARMED = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    typedef enum logic [0:0] {
        ARMED = ST_ARMED,
        HOLD  = ST_HOLD
    } state_e;

    localparam int HEADER_LANE       = 0;
    localparam int SEQ_LANE          = 1;
    localparam int FIRST_SAMPLE_LANE = 2;

    localparam logic [15:0] DEFAULT_HEADER = 16'h1002;

    // Channels are laid out in reverse order: the highest channel sits in
    // the first sample lane and channel 0 ends up in the topmost lane.
    function automatic int sample_lane(input int channels, input int channel);
        return FIRST_SAMPLE_LANE + (channels - 1 - channel);
    endfunction

endpackage

// File: rtl/axis_holdoff_counter.sv
// -----------------------------------------------------------------------------
// axis_holdoff_counter
// Loadable down-counter used to time the holdoff window after each accept.
// Ports:
//   aclk, areset  : clock, asynchronous active-high reset
//   load          : load load_value (has priority over dec)
//   load_value    : value loaded on load
//   dec           : decrement by one (stops at zero)
//   count         : current counter value
//   zero          : count == 0
//   last          : count == 1 (next decrement reaches zero)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module axis_holdoff_counter #(
    parameter int CNTR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  load,
    input  logic [CNTR_WIDTH-1:0] load_value,
    input  logic                  dec,
    output logic [CNTR_WIDTH-1:0] count,
    output logic                  zero,
    output logic                  last
);

    assign zero = (count == '0);
    assign last = (count == CNTR_WIDTH'(1));

    // A load always wins so an accept can restart the window; decrements
    // stop at zero so a stray dec never wraps the counter around.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - CNTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// -----------------------------------------------------------------------------
// axis_packetizer
// Captures a multi-lane sample from an AXI-Stream input, wraps it into a
// packet {samples..., sequence number, header} and presents it on an
// AXI-Stream output. After each accept a programmable holdoff window either
// backpressures the input (cfg_mode=0) or discards incoming samples
// (cfg_mode=1, counted in sts_drop).
// Ports:
//   aclk, areset                 : clock, asynchronous active-high reset
//   cfg_period                   : holdoff cycles after each accepted sample
//   cfg_mode                     : 0 = backpressure, 1 = decimate during holdoff
//   cfg_mask                     : per-channel enable (0 zeroes the lane)
//   s_axis_tdata/tvalid/tready   : sample input stream
//   m_axis_tdata/tvalid/tready   : packet output stream
//   sts_seq                      : sequence number of the next packet
//   sts_drop                     : saturating count of discarded samples
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module axis_packetizer
    import axis_packetizer_pkg::*;
#(
    parameter int          CHANNELS     = 5,
    parameter int          SAMPLE_WIDTH = 16,
    parameter int          CNTR_WIDTH   = 32,
    parameter logic [15:0] HEADER       = DEFAULT_HEADER
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [CNTR_WIDTH-1:0]              cfg_period,
    input  logic                               cfg_mode,
    input  logic [CHANNELS-1:0]                cfg_mask,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]   s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    output logic [(CHANNELS+2)*SAMPLE_WIDTH-1:0] m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [15:0]                        sts_seq,
    output logic [31:0]                        sts_drop
);

    localparam int OUT_W = (CHANNELS + 2) * SAMPLE_WIDTH;

    state_e                state;
    logic                  accept;
    logic                  discard;
    logic                  in_hold;
    logic [CNTR_WIDTH-1:0] hold_count;
    logic                  hold_zero;
    logic                  hold_last;
    logic [OUT_W-1:0]      next_packet;

    assign in_hold = (state == HOLD);
    assign accept  = (state == ARMED) && s_axis_tvalid && s_axis_tready;
    assign discard = in_hold && cfg_mode && s_axis_tvalid && !areset;

    // Input ready: while armed we can take a sample whenever the output
    // register is free or being drained this cycle; during holdoff the mode
    // decides between stalling and swallowing. Reset forces ready low so no
    // sample is ever acknowledged while the block is being cleared.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!areset) begin
            if (state == ARMED) begin
                s_axis_tready = !m_axis_tvalid || m_axis_tready;
            end else begin
                s_axis_tready = cfg_mode;
            end
        end
    end

    // Packet assembly from the live input and the current sequence number;
    // only latched into the output register on an accept, which is what
    // makes cfg_mask effectively sampled at the accept edge.
    always_comb begin
        next_packet = '0;
        next_packet[HEADER_LANE*SAMPLE_WIDTH +: SAMPLE_WIDTH] = SAMPLE_WIDTH'(HEADER);
        next_packet[SEQ_LANE*SAMPLE_WIDTH +: SAMPLE_WIDTH]    = SAMPLE_WIDTH'(sts_seq);
        for (int c = 0; c < CHANNELS; c++) begin
            next_packet[sample_lane(CHANNELS, c)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                s_axis_tdata[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] & {SAMPLE_WIDTH{cfg_mask[c]}};
        end
    end

    axis_holdoff_counter #(
        .CNTR_WIDTH (CNTR_WIDTH)
    ) u_holdoff (
        .aclk       (aclk),
        .areset     (areset),
        .load       (accept),
        .load_value (cfg_period),
        .dec        (in_hold),
        .count      (hold_count),
        .zero       (hold_zero),
        .last       (hold_last)
    );

    // State sequencing: an accept with a non-zero period opens the holdoff
    // window, which closes on the edge where the counter steps 1 -> 0. The
    // zero check is a safety exit so the FSM can never get stuck in HOLD.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ARMED;
        end else if (accept) begin
            state <= (cfg_period != '0) ? HOLD : ARMED;
        end else if (in_hold && (hold_last || hold_zero)) begin
            state <= ARMED;
        end
    end

    // Output register: holds the packet stable until the consumer takes it;
    // a simultaneous accept reloads it so back-to-back packets do not bubble.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (accept) begin
            m_axis_tdata  <= next_packet;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Status counters: the sequence number wraps naturally at 16 bits, the
    // drop counter sticks at all-ones rather than wrapping back to zero.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sts_seq  <= '0;
            sts_drop <= '0;
        end else begin
            if (accept) begin
                sts_seq <= sts_seq + 16'd1;
            end
            if (discard && (sts_drop != '1)) begin
                sts_drop <= sts_drop + 32'd1;
            end
        end
    end

    logic unused_count;
    assign unused_count = ^hold_count;

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 Parameter CHANNELS, default 5, number of input sample lanes (1..16).
REQ-002 Parameter SAMPLE_WIDTH, default 16, bits per lane (>=16).
REQ-003 Parameter CNTR_WIDTH, default 32, holdoff counter width.
REQ-004 Parameter HEADER, default 16'h1002, constant in output lane 0, zero-extended to SAMPLE_WIDTH.
REQ-005 aclk  in  1  sole clock; all logic rising-edge.
REQ-006 areset  in  1  asynchronous, active-high reset.
REQ-007 cfg_period  in  CNTR_WIDTH  holdoff cycles after each accepted sample.
REQ-008 cfg_mode  in  1  0 = backpressure during holdoff, 1 = accept-and-discard (decimate) during holdoff.
REQ-009 cfg_mask  in  CHANNELS  per-channel enable; 0 forces that lane to zero.
REQ-010 s_axis_tdata  in  CHANNELS*SAMPLE_WIDTH  channel c at bits [c*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-011 s_axis_tvalid / s_axis_tready  in / out  1  input handshake.
REQ-012 m_axis_tdata  out  (CHANNELS+2)*SAMPLE_WIDTH  packet word.
REQ-013 m_axis_tvalid / m_axis_tready  out / in  1  output handshake.
REQ-014 sts_seq  out  16  sequence number of the next packet.
REQ-015 sts_drop  out  32  count of samples discarded in mode 1.

Function
REQ-016 Two states: ARMED, HOLD.
REQ-017 ARMED: s_axis_tready = ~m_axis_tvalid | m_axis_tready.
REQ-018 Accept (ARMED, tvalid&tready): register packet; m_axis_tvalid<=1; counter<=cfg_period; sts_seq<=sts_seq+1; next state HOLD if cfg_period!=0, else ARMED.
REQ-019 Packet lanes (lane k = bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]): lane 0 = HEADER; lane 1 = sts_seq before increment, zero-extended; lane CHANNELS+1-c = channel c & {SAMPLE_WIDTH{cfg_mask[c]}}.
REQ-020 cfg_period and cfg_mask are sampled only at the accept edge; cfg_mode is used combinationally every cycle.
REQ-021 HOLD: counter decrements by 1 per cycle regardless of m_axis_tready; leave HOLD on the edge where counter goes 1->0.
REQ-022 Sample accepted at edge t => ARMED again at edge t+cfg_period; earliest next accept at edge t+cfg_period+1.
REQ-023 HOLD, cfg_mode=0: s_axis_tready=0.
REQ-024 HOLD, cfg_mode=1: s_axis_tready=1; each tvalid cycle discards data and increments sts_drop, saturating at 32'hFFFFFFFF; packet register untouched.
REQ-025 m_axis_tvalid is held with stable m_axis_tdata until m_axis_tready; clears on handshake unless a new accept occurs that edge (then reloads, stays 1).
REQ-026 sts_seq wraps 16'hFFFF -> 16'h0000.
REQ-027 A cfg_mode change mid-HOLD takes effect on the next cycle; the counter is unaffected.

Reset
REQ-028 While areset=1: state ARMED, counter 0, m_axis_tdata 0, m_axis_tvalid 0, sts_seq 0, sts_drop 0, s_axis_tready 0.
REQ-029 areset asserted mid-HOLD or with a pending packet discards that packet immediately (asynchronously) without emitting it.
REQ-030 First accept possible on the first rising edge after areset deasserts.

Structure
REQ-031 Package axis_packetizer_pkg holds the state enum, lane-index constants (HEADER_LANE=0, SEQ_LANE=1, first-sample lane) and the default HEADER value.
REQ-032 Holdoff counter (load, decrement, zero flag) lives in sub-module axis_holdoff_counter, parameterised by CNTR_WIDTH.

Verification
REQ-033 CHANNELS=5, cfg_period=3, mode 0, tready=1, tvalid=1 continuous, channel c = 16'h1000+c -> accepts at edges 0,4,8; lanes 6..2 = 1000..1004, lane 1 = 0,1,2, lane 0 = 1002.
REQ-034 cfg_period=0, tready=1, tvalid=1 continuous -> one accept per cycle, 8 packets in 8 cycles, sts_seq=8.
REQ-035 mode 1, cfg_period=4, tvalid=1 continuous for 10 cycles -> 2 packets, sts_drop=8, s_axis_tready=1 throughout.
REQ-036 cfg_period=0, m_axis_tready=0 for 5 cycles after first packet -> s_axis_tready=0 and m_axis_tdata stable for those 5 cycles; second packet accepted in the same cycle tready rises.
REQ-037 cfg_mask=5'b00101 -> lanes for channels 1,3,4 are zero; lanes for channels 0,2 pass data.
REQ-038 areset pulsed 2 cycles into HOLD with m_axis_tvalid=1 -> outputs zero immediately; sts_seq=0; next sample produces lane 1 = 0.
